// File: rtl/sra_reg_bank_if.sv
// Request/response simple-stream bundle for the register bank.
// The master issues requests and accepts responses; the slave serves them.
interface sra_reg_bank_if #(
  parameter int DW          = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int M_USER_BITS = 2,
  parameter int S_USER_BITS = 2
);
  logic                          req_valid;
  logic                          req_ready;
  logic [DW-1:0]                 req_data;
  logic [M_USER_BITS+ADDR_WIDTH-1:0] req_user;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [DW-1:0]                 rsp_data;
  logic [S_USER_BITS+ADDR_WIDTH-1:0] rsp_user;

  modport master (
    output req_valid, req_data, req_user, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_user
  );

  modport slave (
    input  req_valid, req_data, req_user, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_user
  );
endinterface

// File: rtl/sra_reg_bank.sv
// Register bank behind a one-deep request/response stream: RW registers,
// RO registers fed from hw_in, error on bad address or write to RO.
module sra_reg_bank #(
  parameter int                    DATA_WIDTH_BYTES = 4,
  parameter int                    ADDR_WIDTH       = 8,
  parameter int                    M_USER_BITS      = 2,
  parameter int                    S_USER_BITS      = 2,
  parameter int                    NUM_REGS         = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK          = '0,
  localparam int                   DW               = 8 * DATA_WIDTH_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sra_reg_bank_if.slave          bus,
  input  logic [NUM_REGS*DW-1:0] hw_in,
  output logic [NUM_REGS*DW-1:0] reg_out,
  output logic [NUM_REGS-1:0]    wr_pulse
);

  logic [DW-1:0]          regs [NUM_REGS];
  logic [ADDR_WIDTH-1:0]  addr_p0;
  logic                   op_p0;
  logic                   tag_p0;
  logic                   accept_p0;
  logic                   in_range_p0;
  logic                   is_ro_p0;
  logic                   err_p0;
  logic [DW-1:0]          rd_data_p0;
  logic [NUM_REGS-1:0]    wr_hit_p0;
  logic [S_USER_BITS-1:0] s_bits_p0;

  logic                   vld_p1;
  logic [DW-1:0]          rsp_data_p1;
  logic [S_USER_BITS+ADDR_WIDTH-1:0] rsp_user_p1;
  logic [NUM_REGS-1:0]    wr_pulse_p1;

  // Stage p0: decode the request presented on the bus this cycle.
  assign addr_p0       = bus.req_user[ADDR_WIDTH-1:0];
  assign op_p0         = bus.req_user[ADDR_WIDTH];
  assign tag_p0        = bus.req_user[ADDR_WIDTH+1];
  assign bus.req_ready = rst_n && (!vld_p1 || bus.rsp_ready);
  assign accept_p0     = bus.req_valid && bus.req_ready;

  always_comb begin
    in_range_p0 = 1'b0;
    is_ro_p0    = 1'b0;
    rd_data_p0  = '0;
    wr_hit_p0   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_p0 == ADDR_WIDTH'(i)) begin
        in_range_p0  = 1'b1;
        is_ro_p0     = RO_MASK[i];
        // RW reads see the pre-edge value, so a same-edge write is not visible.
        rd_data_p0   = RO_MASK[i] ? hw_in[i*DW +: DW] : regs[i];
        wr_hit_p0[i] = accept_p0 && op_p0 && !RO_MASK[i];
      end
    end
  end

  assign err_p0 = !in_range_p0 || (op_p0 && is_ro_p0);

  always_comb begin
    s_bits_p0    = '0;
    s_bits_p0[0] = err_p0;
    s_bits_p0[1] = tag_p0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst_n)            regs[i] <= '0;
      else if (wr_hit_p0[i]) regs[i] <= bus.req_data;
    end
  end

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!RO_MASK[i]) reg_out[i*DW +: DW] = regs[i];
    end
  end

  // Stage p1: response holding register and write strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      rsp_data_p1 <= '0;
      rsp_user_p1 <= '0;
      wr_pulse_p1 <= '0;
    end else begin
      wr_pulse_p1 <= wr_hit_p0;
      if (accept_p0) begin
        vld_p1      <= 1'b1;
        rsp_data_p1 <= (op_p0 || err_p0) ? '0 : rd_data_p0;
        rsp_user_p1 <= {s_bits_p0, addr_p0};
      end else if (bus.rsp_ready) begin
        vld_p1      <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = vld_p1;
  assign bus.rsp_data  = rsp_data_p1;
  assign bus.rsp_user  = rsp_user_p1;
  assign wr_pulse      = wr_pulse_p1;

endmodule
